// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
//   Command-driven sequencer for an 8-bit Fibonacci LFSR. A (seed, length) job is
//   accepted over a valid/ready command port. The sequencer then streams exactly
//   `length` LFSR states over a valid/ready output port, with backpressure, and
//   pulses done when the job completes normally. abort cancels a running job.
//
// Ports
//   i_clk         clock, all state on posedge
//   i_rst_n       asynchronous active-low reset
//   i_cmd_valid   job request
//   o_cmd_ready   high only in IDLE
//   i_cmd_seed    LFSR seed, sampled on command handshake (zero is forced to 8'h01)
//   i_cmd_len     number of output beats, sampled on command handshake
//   i_abort       synchronous job cancel, effective in RUN only
//   o_out_valid   o_out_data holds a valid LFSR state
//   i_out_ready   consumer accepts the beat
//   o_out_data    current LFSR state
//   o_busy        high in RUN and DONE
//   o_done        one-cycle pulse at normal job completion
module lfsr_seq_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [7:0]       i_cmd_seed,
    input  logic [CNT_W-1:0] i_cmd_len,
    input  logic             i_abort,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [7:0]       o_out_data,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           r_state;
    logic [7:0]       r_lfsr;
    logic [CNT_W-1:0] r_remain;

    logic [7:0]       w_lfsr_next;
    logic             w_fb;
    logic             w_beat;

    // Taps 4,3,2,0; shift right with feedback entering at bit 7.
    always_comb begin
        w_fb        = r_lfsr[4] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0];
        w_lfsr_next = {w_fb, r_lfsr[7:1]};
    end

    // All handshake outputs are decoded from state only, so there is no
    // combinational path from i_out_ready to o_out_valid.
    always_comb begin
        o_cmd_ready = (r_state == StIdle);
        o_out_valid = (r_state == StRun);
        o_busy      = (r_state == StRun) || (r_state == StDone);
        o_done      = (r_state == StDone);
        o_out_data  = r_lfsr;
    end

    assign w_beat = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_lfsr   <= 8'h01;
            r_remain <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        // All-zero is the LFSR lock-up state, so replace it.
                        r_lfsr   <= (i_cmd_seed == 8'h00) ? 8'h01 : i_cmd_seed;
                        r_remain <= i_cmd_len;
                        r_state  <= (i_cmd_len != '0) ? StRun : StDone;
                    end
                end
                StRun: begin
                    // A beat taken in the abort cycle still counts as delivered.
                    if (w_beat) begin
                        r_lfsr   <= w_lfsr_next;
                        r_remain <= r_remain - CNT_W'(1);
                    end
                    if (i_abort) begin
                        r_state <= StIdle;
                    end else if (w_beat && (r_remain == CNT_W'(1))) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
module tb_lfsr_seq_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_seed;
    logic [CNT_W-1:0] cmd_len;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_seed (cmd_seed),
        .i_cmd_len  (cmd_len),
        .i_abort    (abort),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle command; returns just after the accepting edge.
    task automatic send_cmd(input logic [7:0] seed, input logic [CNT_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_seed  = seed;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [7:0] exp1 [6];
    logic [7:0] exp2 [3];

    initial begin
        exp1 = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        exp2 = '{8'h01, 8'h80, 8'h40};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_seed  = 8'h00;
        cmd_len   = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'h01);
        rst_n = 1'b1;
        tick();

        // 1: seed 01, len 6, continuous ready
        send_cmd(8'h01, 8'd6);
        chk("t1_cmd_ready_run", {31'd0, cmd_ready}, 32'd0);
        chk("t1_busy_run", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t1_valid%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t1_data%0d", i), {24'd0, out_data}, {24'd0, exp1[i]});
            tick();
        end
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_valid_done", {31'd0, out_valid}, 32'd0);
        chk("t1_cmd_ready_done", {31'd0, cmd_ready}, 32'd0);
        chk("t1_busy_done", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        chk("t1_done_idle", {31'd0, done}, 32'd0);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);

        // 2: zero seed forced to 01
        send_cmd(8'h00, 8'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_data%0d", i), {24'd0, out_data}, {24'd0, exp2[i]});
            tick();
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        tick();

        // 3: backpressure holds data
        send_cmd(8'h01, 8'd4);
        chk("t3_data0", {24'd0, out_data}, 32'h01);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_hold_data%0d", i), {24'd0, out_data}, 32'h80);
            chk($sformatf("t3_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        chk("t3_data1", {24'd0, out_data}, 32'h80);
        tick();
        chk("t3_data2", {24'd0, out_data}, 32'h40);
        tick();
        chk("t3_data3", {24'd0, out_data}, 32'h20);
        chk("t3_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("t3_done", {31'd0, done}, 32'd1);
        tick();

        // 4: len 0, cmd_valid held through DONE
        cmd_valid = 1'b1;
        cmd_seed  = 8'h55;
        cmd_len   = 8'd0;
        tick();
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_valid_done", {31'd0, out_valid}, 32'd0);
        chk("t4_cmd_ready_done", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("t4_done_idle", {31'd0, done}, 32'd0);
        chk("t4_valid_idle", {31'd0, out_valid}, 32'd0);
        chk("t4_busy_idle", {31'd0, busy}, 32'd0);
        chk("t4_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b0;
        tick();

        // 5: abort after 2 beats; beat 88 taken in the abort cycle
        send_cmd(8'h10, 8'd5);
        chk("t5_data0", {24'd0, out_data}, 32'h10);
        tick();
        chk("t5_data1", {24'd0, out_data}, 32'h88);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_valid_abort", {31'd0, out_valid}, 32'd0);
        chk("t5_done_abort", {31'd0, done}, 32'd0);
        chk("t5_cmd_ready_abort", {31'd0, cmd_ready}, 32'd1);
        chk("t5_lfsr_kept", {24'd0, out_data}, 32'hC4);
        tick();
        chk("t5_done_later", {31'd0, done}, 32'd0);
        chk("t5_valid_later", {31'd0, out_valid}, 32'd0);

        // 6: async reset mid-RUN with out_ready low
        out_ready = 1'b0;
        send_cmd(8'h01, 8'd5);
        tick();
        chk("t6_valid_run", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_rst_data", {24'd0, out_data}, 32'h01);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send_cmd(8'hC4, 8'd1);
        chk("t6_data", {24'd0, out_data}, 32'hC4);
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t6_done", {31'd0, done}, 32'd1);
        tick();
        chk("t6_idle", {31'd0, cmd_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
